lpc_host: RTL

Initiator side of the LPC bus: issues LPC 1.1 I/O and memory read/write cycles on request, driving `lpc_ad` and `lpc_frame` toward peripherals and the bus sniffer. It sits between an internal request/response port and the board-level LPC pins. It returns read data or error status per transaction.

---
 rtl/lpc_pkg.sv | 37 +++
 rtl/lpc_sync_timer.sv | 33 +++
 rtl/lpc_host.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/lpc_pkg.sv
// Shared LPC definitions: FSM states, cycle-type codes, SYNC codes and bus nibbles.
// Used by lpc_host and the bus sniffer.
package lpc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_CYCDIR,
    ST_ADDR,
    ST_WDATA,
    ST_TAR_H,
    ST_TAR_Z,
    ST_SYNC,
    ST_RDATA,
    ST_TAR_P,
    ST_DONE,
    ST_ABORT
  } lpc_state_e;

  localparam logic [3:0] CYC_IO_RD  = 4'b0000;
  localparam logic [3:0] CYC_IO_WR  = 4'b0010;
  localparam logic [3:0] CYC_MEM_RD = 4'b0100;
  localparam logic [3:0] CYC_MEM_WR = 4'b0110;

  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_SHORT = 4'b0101;
  localparam logic [3:0] SYNC_LONG  = 4'b0110;
  localparam logic [3:0] SYNC_ERR   = 4'b1010;

  localparam logic [3:0] LAD_START  = 4'b0000;
  localparam logic [3:0] LAD_IDLE   = 4'b1111;

  function automatic logic cyc_is_mem(input logic [3:0] cyctype_dir);
    return cyctype_dir[3:2] == 2'b01;
  endfunction

endpackage

// File: rtl/lpc_sync_timer.sv
// lpc_sync_timer: counts consecutive 1111 SYNC samples and flags expiry at LIMIT.
// Latency: expired is combinational on the sample that reaches LIMIT.
// Backpressure: none; clear restarts the count on SYNC entry.
module lpc_sync_timer #(
  parameter int unsigned LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       active,
  input  logic [3:0] nibble,
  output logic       expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;
  logic         idle_nib;

  assign idle_nib = (nibble == 4'b1111);
  assign expired  = active && idle_nib && (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (active) begin
      cnt <= idle_nib ? cnt + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/lpc_host.sv
// lpc_host: LPC 1.1 initiator for I/O and memory cycles; SYNC timeout/abort built only with LPC_HOST_TIMEOUT_EN.
// Latency: START the cycle after acceptance; DONE 14 (I/O) / 18 (memory) clocks later plus SYNC waits.
// Backpressure: req_ready only in IDLE; rsp_valid is a one-cycle pulse that cannot be stalled.
module lpc_host
`ifdef LPC_HOST_TIMEOUT_EN
  #(parameter int unsigned SYNC_TIMEOUT = 3)
`endif
  (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic [3:0]  lpc_ad_in,
  output logic [3:0]  lpc_ad_out,
  output logic        lpc_ad_oe,
  output logic        lpc_frame,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cyctype_dir,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_error
);

  import lpc_pkg::*;

  lpc_state_e  state, nxt_state;
  logic [2:0]  nib_cnt;
  logic [3:0]  cyc_q;
  logic [31:0] addr_sh;
  logic [7:0]  wdat_q;
  logic [7:0]  rdat_q;
  logic        err_q;
  logic        ready_q;
  logic        accept;
  logic        is_wr;
  logic        sync_exit;
  logic [2:0]  last_addr_nib;

  assign accept        = req_valid && req_ready;
  assign is_wr         = cyc_q[1];
  assign sync_exit     = (lpc_ad_in == SYNC_READY) || (lpc_ad_in == SYNC_ERR);
  assign last_addr_nib = cyc_is_mem(cyc_q) ? 3'd7 : 3'd3;

  // ready_q keeps req_ready low until the first edge after reset release.
  assign req_ready = ready_q && (state == ST_IDLE);
  assign rsp_valid = (state == ST_DONE);
  assign rsp_data  = rdat_q;
  assign rsp_error = err_q;

`ifdef LPC_HOST_TIMEOUT_EN
  logic sync_expired;

  lpc_sync_timer #(
    .LIMIT (SYNC_TIMEOUT)
  ) u_sync_timer (
    .clk     (lpc_clock),
    .rst_n   (lpc_reset),
    .clear   (state == ST_TAR_Z),
    .active  (state == ST_SYNC),
    .nibble  (lpc_ad_in),
    .expired (sync_expired)
  );
`endif

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state   <= ST_IDLE;
      nib_cnt <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= nxt_state;
      nib_cnt <= (state != nxt_state) ? 3'd0 : nib_cnt + 3'd1;
      ready_q <= 1'b1;
    end
  end

  always_comb begin
    nxt_state  = state;
    lpc_frame  = 1'b1;
    lpc_ad_oe  = 1'b0;
    lpc_ad_out = LAD_IDLE;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          nxt_state = req_cyctype_dir[3] ? ST_DONE : ST_START;
        end
      end
      ST_START: begin
        lpc_frame  = 1'b0;
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = LAD_START;
        nxt_state  = ST_CYCDIR;
      end
      ST_CYCDIR: begin
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = cyc_q;
        nxt_state  = ST_ADDR;
      end
      ST_ADDR: begin
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = addr_sh[31:28];
        if (nib_cnt == last_addr_nib) begin
          nxt_state = is_wr ? ST_WDATA : ST_TAR_H;
        end
      end
      ST_WDATA: begin
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = nib_cnt[0] ? wdat_q[7:4] : wdat_q[3:0];
        if (nib_cnt[0]) begin
          nxt_state = ST_TAR_H;
        end
      end
      ST_TAR_H: begin
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = LAD_IDLE;
        nxt_state  = ST_TAR_Z;
      end
      ST_TAR_Z: begin
        nxt_state = ST_SYNC;
      end
      ST_SYNC: begin
        if (sync_exit) begin
          nxt_state = is_wr ? ST_TAR_P : ST_RDATA;
        end
`ifdef LPC_HOST_TIMEOUT_EN
        else if (sync_expired) begin
          nxt_state = ST_ABORT;
        end
`endif
      end
      ST_RDATA: begin
        if (nib_cnt[0]) begin
          nxt_state = ST_TAR_P;
        end
      end
      ST_TAR_P: begin
        if (nib_cnt[0]) begin
          nxt_state = ST_DONE;
        end
      end
      ST_DONE: begin
        nxt_state = ST_IDLE;
      end
`ifdef LPC_HOST_TIMEOUT_EN
      // Four LFRAME# low cycles with LAD high, then one released cycle.
      ST_ABORT: begin
        if (nib_cnt == 3'd4) begin
          nxt_state = ST_DONE;
        end else begin
          lpc_frame  = 1'b0;
          lpc_ad_oe  = 1'b1;
          lpc_ad_out = LAD_IDLE;
        end
      end
`endif
      default: begin
        nxt_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      cyc_q   <= '0;
      addr_sh <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cyc_q   <= req_cyctype_dir;
        // I/O addresses are pre-aligned so the next nibble is always [31:28].
        addr_sh <= cyc_is_mem(req_cyctype_dir) ? req_addr : {req_addr[15:0], 16'h0000};
        wdat_q  <= req_data;
        rdat_q  <= '0;
        err_q   <= req_cyctype_dir[3];
      end else if (state == ST_ADDR) begin
        addr_sh <= {addr_sh[27:0], 4'h0};
      end

      if (state == ST_SYNC && lpc_ad_in == SYNC_ERR) begin
        err_q <= 1'b1;
      end

      if (state == ST_RDATA) begin
        if (nib_cnt[0]) begin
          rdat_q[7:4] <= lpc_ad_in;
        end else begin
          rdat_q[3:0] <= lpc_ad_in;
        end
      end

`ifdef LPC_HOST_TIMEOUT_EN
      if (state == ST_ABORT) begin
        err_q  <= 1'b1;
        rdat_q <= '0;
      end
`endif
    end
  end

endmodule
